// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix scan controller.
// MATRIX_BCM_EN selects three binary-coded-modulation bit-planes instead of one.
package matrix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  localparam int unsigned MATRIX_COLS = 64;
  localparam int unsigned MATRIX_ROWS = 16;

`ifdef MATRIX_BCM_EN
  localparam int unsigned MATRIX_PLANES = 3;
`else
  localparam int unsigned MATRIX_PLANES = 1;
`endif

endpackage

// File: rtl/matrix_oe_timer.sv
// Down-counter that times the panel output-enable window.
// done is high during the last cycle of a window of 'load' cycles started by 'start'.
module matrix_oe_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         done
);

  logic [W-1:0] cnt;

  // done is registered one cycle early so it lines up with the final count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      cnt  <= load;
      done <= (load == W'(1));
    end else if (cnt != '0) begin
      cnt  <= cnt - W'(1);
      done <= (cnt == W'(2));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// HUB75-style LED matrix scan controller: fetch, shift, latch and display each row.
// Define MATRIX_BCM_EN for three bit-planes with doubling display windows.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned BASE_ON = 16,
  parameter int unsigned COLS    = MATRIX_COLS,
  parameter int unsigned ROWS    = MATRIX_ROWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       fb_req,
  output logic [9:0] fb_addr,
  output logic [1:0] fb_plane,
  input  logic       fb_ack,
  input  logic [2:0] fb_rgb0,
  input  logic [2:0] fb_rgb1,
  output logic [2:0] rgb0,
  output logic [2:0] rgb1,
  output logic       sclk,
  output logic       lat,
  output logic       oe_n,
  output logic [3:0] row_addr,
  output logic       frame_done
);

  localparam int unsigned TMR_W = $clog2((BASE_ON << (MATRIX_PLANES - 1)) + 1);

  state_t           state;
  logic [5:0]       col;
  logic [3:0]       row;
  logic [1:0]       plane;
  logic             last_col_c;
  logic             last_row_c;
  logic             row_step_c;
  logic             frame_end_c;
  logic [1:0]       plane_nxt_c;
  logic [3:0]       row_nxt_c;
  logic             tmr_start_c;
  logic [TMR_W-1:0] tmr_load_c;
  logic             tmr_done;

  assign last_col_c = (col == 6'(COLS - 1));
  assign last_row_c = (row == 4'(ROWS - 1));

  // Plane/row sequencing applied when a display window ends
`ifdef MATRIX_BCM_EN
  logic last_plane_c;
  assign last_plane_c = (plane == 2'(MATRIX_PLANES - 1));
  assign plane_nxt_c  = last_plane_c ? 2'd0 : plane + 2'd1;
  assign row_step_c   = last_plane_c;
`else
  assign plane_nxt_c  = 2'd0;
  assign row_step_c   = 1'b1;
`endif

  assign row_nxt_c   = row_step_c ? (last_row_c ? 4'd0 : row + 4'd1) : row;
  assign frame_end_c = row_step_c && last_row_c;

  assign fb_plane    = plane;
  assign tmr_start_c = (state == ST_LATCH);
  assign tmr_load_c  = TMR_W'(BASE_ON) << plane;

  matrix_oe_timer #(
    .W(TMR_W)
  ) u_oe_timer (
    .clk  (clk),
    .rst  (rst),
    .start(tmr_start_c),
    .load (tmr_load_c),
    .done (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      fb_req     <= 1'b0;
      fb_addr    <= '0;
      rgb0       <= '0;
      rgb1       <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      row_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      sclk       <= 1'b0;
      lat        <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en) begin
            state   <= ST_FETCH;
            fb_req  <= 1'b1;
            fb_addr <= {row, col};
          end
        end
        ST_FETCH: begin
          if (fb_ack) begin
            state  <= ST_SHIFT;
            fb_req <= 1'b0;
            rgb0   <= fb_rgb0;
            rgb1   <= fb_rgb1;
            sclk   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (last_col_c) begin
            col   <= '0;
            state <= ST_BLANK;
          end else begin
            col     <= col + 6'd1;
            fb_req  <= 1'b1;
            fb_addr <= {row, col + 6'd1};
            state   <= ST_FETCH;
          end
        end
        ST_BLANK: begin
          lat      <= 1'b1;
          row_addr <= row;
          state    <= ST_LATCH;
        end
        ST_LATCH: begin
          oe_n  <= 1'b0;
          state <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          // en is only honoured at a frame boundary so frames always complete
          if (tmr_done) begin
            oe_n       <= 1'b1;
            plane      <= plane_nxt_c;
            row        <= row_nxt_c;
            fb_addr    <= {row_nxt_c, 6'd0};
            frame_done <= frame_end_c;
            if (frame_end_c && !en) begin
              state <= ST_IDLE;
            end else begin
              state  <= ST_FETCH;
              fb_req <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized bench for matrix_scan_ctrl: a procedural scan model predicts every output each cycle,
// and literal checks pin pulse counts, window lengths and the directed reset/ack/stop scenarios.
module tb_matrix_scan_ctrl;
  import matrix_pkg::*;

  localparam int unsigned BASE_ON = 16;
  localparam int unsigned COLS    = 64;
  localparam int unsigned ROWS    = 16;
  localparam int unsigned PLANES  = MATRIX_PLANES;
  localparam int          LIMIT   = 30000;
  localparam logic [26:0] RESET_VEC = 27'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fb_ack = 1'b0;
  logic [2:0] fb_rgb0 = 3'd0;
  logic [2:0] fb_rgb1 = 3'd0;
  logic       fb_req;
  logic [9:0] fb_addr;
  logic [1:0] fb_plane;
  logic [2:0] rgb0, rgb1;
  logic       sclk, lat, oe_n, frame_done;
  logic [3:0] row_addr;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .BASE_ON(BASE_ON),
    .COLS   (COLS),
    .ROWS   (ROWS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fb_req    (fb_req),
    .fb_addr   (fb_addr),
    .fb_plane  (fb_plane),
    .fb_ack    (fb_ack),
    .fb_rgb0   (fb_rgb0),
    .fb_rgb1   (fb_rgb1),
    .rgb0      (rgb0),
    .rgb1      (rgb1),
    .sclk      (sclk),
    .lat       (lat),
    .oe_n      (oe_n),
    .row_addr  (row_addr),
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [26:0] pack_out();
    return {fb_req, fb_addr, fb_plane, rgb0, rgb1, sclk, lat, oe_n, row_addr, frame_done};
  endfunction

  // Expected outputs for the current cycle
  logic       exp_req, exp_sclk, exp_lat, exp_oe_n, exp_fd;
  logic [9:0] exp_addr;
  logic [1:0] exp_plane;
  logic [2:0] exp_rgb0, exp_rgb1;
  logic [3:0] exp_row;
  bit         aborted;

  task automatic exp_reset();
    exp_req = 0; exp_addr = '0; exp_plane = '0; exp_rgb0 = '0; exp_rgb1 = '0;
    exp_sclk = 0; exp_lat = 0; exp_oe_n = 1; exp_row = '0; exp_fd = 0;
  endtask

  task automatic tick();
    @(posedge clk or posedge rst);
    if (rst) aborted = 1'b1;
  endtask

  // Walks frames as nested row/plane/column loops; returns when reset hits
  task automatic model_frames();
    bit go;
    forever begin
      do begin
        tick(); if (aborted) return;
        exp_fd = 0;
      end while (!en);
      go = 1'b1;
      while (go) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          for (int p = 0; p < int'(PLANES); p++) begin
            for (int c = 0; c < int'(COLS); c++) begin
              exp_req = 1; exp_addr = 10'(r * 64 + c); exp_plane = 2'(p);
              exp_sclk = 0; exp_oe_n = 1;
              forever begin
                tick(); if (aborted) return;
                exp_fd = 0;
                if (fb_ack) break;
              end
              exp_req = 0; exp_sclk = 1; exp_rgb0 = fb_rgb0; exp_rgb1 = fb_rgb1;
              tick(); if (aborted) return;
              exp_sclk = 0;
            end
            tick(); if (aborted) return;
            exp_lat = 1; exp_row = 4'(r);
            tick(); if (aborted) return;
            exp_lat = 0; exp_oe_n = 0;
            for (int k = 0; k < int'(BASE_ON << p); k++) begin
              tick(); if (aborted) return;
            end
            exp_oe_n = 1;
          end
        end
        exp_addr = '0; exp_plane = '0; exp_fd = 1;
        go = en;
        if (!go) exp_req = 0;
      end
    end
  endtask

  initial begin : model
    forever begin
      aborted = 1'b0;
      exp_reset();
      wait (!rst);
      model_frames();
    end
  end

  // Per-cycle compare plus pulse/run-length bookkeeping
  int sclk_cnt = 0, lat_cnt = 0, oe_run = 0, run_idx = 0;

  always @(negedge clk) begin
    check("outputs", 32'(pack_out()),
          32'({exp_req, exp_addr, exp_plane, exp_rgb0, exp_rgb1, exp_sclk, exp_lat, exp_oe_n,
               exp_row, exp_fd}));
    if (rst) begin
      sclk_cnt = 0; lat_cnt = 0; oe_run = 0; run_idx = 0;
    end else begin
      if (sclk) sclk_cnt++;
      if (lat) begin
        check("sclk_per_lat", sclk_cnt, 64);
        sclk_cnt = 0;
        lat_cnt++;
      end
      if (!oe_n) oe_run++;
      else if (oe_run != 0) begin
        check("oe_low_run", oe_run, 16 << (run_idx % int'(PLANES)));
        run_idx++;
        oe_run = 0;
      end
      if (frame_done) begin
        check("fd_row_addr", row_addr, 15);
        check("fd_next_addr", fb_addr, 0);
        check("lat_per_frame", lat_cnt, 16 * int'(PLANES));
        lat_cnt = 0;
      end
    end
    if (n_fail >= 30) begin
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic step();
    @(negedge clk);
    fb_ack  = ($urandom_range(0, 3) != 0);
    fb_rgb0 = 3'($urandom);
    fb_rgb1 = 3'($urandom);
  endtask

  initial begin : stim
    int cyc;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(pack_out()), 32'(RESET_VEC));
    rst = 1'b0;
    repeat (5) step();
    check("idle_no_req", {fb_req, oe_n}, {1'b0, 1'b1});

    // Reset in the middle of fetching row 3, column 10
    en = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (!(fb_req && fb_addr == 10'd202) && cyc < LIMIT);
    check("reach_row3_col10", {fb_req, fb_addr}, {1'b1, 10'd202});
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 32'(pack_out()), 32'(RESET_VEC));
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;
    do begin step(); cyc++; end while (!fb_req && cyc < 100);
    check("first_addr_after_reset", {fb_req, fb_addr, fb_plane}, {1'b1, 10'd0, 2'd0});

    // Hold off the acknowledge for column 7
    cyc = 0;
    do begin step(); cyc++; end while (!(fb_req && fb_addr[5:0] == 6'd7) && cyc < 1000);
    fb_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("ack_wait_hold", {fb_req, fb_addr, sclk}, {1'b1, 10'd7, 1'b0});
      @(negedge clk);
      fb_ack = (i == 4);
    end
    step();
    check("sclk_after_ack", {sclk, fb_req}, {1'b1, 1'b0});

    // Frame end with en high runs straight into the next frame
    cyc = 0;
    do begin step(); cyc++; end while (!frame_done && cyc < LIMIT);
    check("frame1_done_b2b", {frame_done, fb_req, fb_addr, row_addr},
          {1'b1, 1'b1, 10'd0, 4'd15});

    // Drop en mid-frame: the frame completes, then the controller idles
    cyc = 0;
    do begin step(); cyc++; end while (row_addr != 4'd8 && cyc < LIMIT);
    check("reach_row8", row_addr, 8);
    en = 1'b0;
    cyc = 0;
    do begin step(); cyc++; end while (!frame_done && cyc < LIMIT);
    check("frame2_done_idle", {frame_done, fb_req, oe_n, row_addr},
          {1'b1, 1'b0, 1'b1, 4'd15});
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_after_stop", {fb_req, oe_n, sclk, lat, frame_done},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
